// File: rtl/cond_logic.sv
// Condition evaluation and write gating: holds the architectural {N,Z,C,V} flags,
// decodes the instruction condition field against them and gates controller write strobes.
module cond_logic #(
    parameter int         n           = 4,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);

    // The flag interface stays 4 bits wide whatever the ALU data width is.
    localparam int FLAG_W = (n > 0) ? 4 : 4;

    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;
    logic              cond_ex;
    logic              flag_n;
    logic              flag_z;
    logic              flag_c;
    logic              flag_v;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // Decode uses only stored flags, so an instruction never sees its own flag update.
    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (FlagW[1] && cond_ex) begin
            flags_d[3:2] = ALUFlags[3:2];
        end
        if (FlagW[0] && cond_ex) begin
            flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= RESET_FLAGS;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Strobes are held low while reset is asserted; CondEx and Flags stay visible.
    assign PCSrc    = ~reset & PCS & cond_ex;
    assign RegWrite = ~reset & RegW & cond_ex & ~NoWrite;
    assign MemWrite = ~reset & MemW & cond_ex;
    assign CondEx   = cond_ex;
    assign Flags    = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
// Directed self-checking bench for cond_logic: reset, flag capture latency,
// partial writes, condition-failed suppression, compare ops and a full decode sweep.
module tb_cond_logic;

    logic       clk;
    logic       reset;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic [1:0] flag_w;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       no_write;
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;
    logic       cond_ex;
    logic [3:0] flags;

    int test_count = 0;
    int fail_count = 0;

    cond_logic #(
        .n          (4),
        .RESET_FLAGS(4'b0000)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .Cond    (cond),
        .ALUFlags(alu_flags),
        .FlagW   (flag_w),
        .PCS     (pcs),
        .RegW    (reg_w),
        .MemW    (mem_w),
        .NoWrite (no_write),
        .PCSrc   (pc_src),
        .RegWrite(reg_write),
        .MemWrite(mem_write),
        .CondEx  (cond_ex),
        .Flags   (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode written independently from the table: odd codes invert the even one.
    function automatic logic expCond(input logic [3:0] c, input logic [3:0] f);
        logic fn, fz, fc, fv, base;
        fn = f[3];
        fz = f[2];
        fc = f[1];
        fv = f[0];
        case (c[3:1])
            3'd0:    base = fz;
            3'd1:    base = fc;
            3'd2:    base = fn;
            3'd3:    base = fv;
            3'd4:    base = fc && !fz;
            3'd5:    base = (fn == fv);
            3'd6:    base = !fz && (fn == fv);
            default: base = 1'b1;
        endcase
        if (c == 4'b1111) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    task automatic checkOutput(input string tag, input logic [3:0] actual, input logic [3:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw,
                                 input logic p, input logic rw, input logic mw, input logic nw);
        cond      = c;
        alu_flags = af;
        flag_w    = fw;
        pcs       = p;
        reg_w     = rw;
        mem_w     = mw;
        no_write  = nw;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loads the flag register through an always-executed write of all four flags.
    task automatic loadFlags(input logic [3:0] f);
        applyStimulus(4'b1110, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("reset_flags", flags, 4'b0000);
        checkOutput("reset_pcsrc", pc_src, 1'b0);
        checkOutput("reset_regwrite", reg_write, 1'b0);
        checkOutput("reset_memwrite", mem_write, 1'b0);
        checkOutput("reset_condex_al", cond_ex, 1'b1);
        applyStimulus(4'b0000, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("reset_condex_eq", cond_ex, 1'b0);
        reset = 1'b0;

        applyStimulus(4'b1110, 4'b1001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("capture_condex", cond_ex, 1'b1);
        checkOutput("capture_before_edge", flags, 4'b0000);
        tick();
        checkOutput("capture_flags", flags, 4'b1001);
        applyStimulus(4'b1011, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("latency_lt", cond_ex, 1'b0);
        applyStimulus(4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("latency_ge", cond_ex, 1'b1);
        tick();
        checkOutput("hold_flags", flags, 4'b1001);

        applyStimulus(4'b1110, 4'b0110, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("partial_nz", flags, 4'b0101);
        applyStimulus(4'b1110, 4'b1010, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("partial_cv", flags, 4'b0110);

        loadFlags(4'b0100);
        applyStimulus(4'b0001, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("suppress_condex", cond_ex, 1'b0);
        checkOutput("suppress_pcsrc", pc_src, 1'b0);
        checkOutput("suppress_regwrite", reg_write, 1'b0);
        checkOutput("suppress_memwrite", mem_write, 1'b0);
        tick();
        checkOutput("suppress_flags", flags, 4'b0100);

        applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("pass_pcsrc", pc_src, 1'b1);
        checkOutput("pass_regwrite", reg_write, 1'b1);
        checkOutput("pass_memwrite", mem_write, 1'b1);
        applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("nowrite_regwrite", reg_write, 1'b0);
        checkOutput("nowrite_pcsrc", pc_src, 1'b1);
        checkOutput("nowrite_memwrite", mem_write, 1'b1);

        loadFlags(4'b0000);
        applyStimulus(4'b1110, 4'b0110, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("cmp_regwrite", reg_write, 1'b0);
        tick();
        checkOutput("cmp_flags", flags, 4'b0110);
        applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("cmp_eq", cond_ex, 1'b1);

        for (int f = 0; f < 16; f++) begin
            loadFlags(4'(f));
            checkOutput($sformatf("sweep_load_%0d", f), flags, 4'(f));
            for (int c = 0; c < 16; c++) begin
                applyStimulus(4'(c), 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
                checkOutput($sformatf("sweep_f%0d_c%0d", f, c), cond_ex, expCond(4'(c), 4'(f)));
            end
        end

        loadFlags(4'b0011);
        reset = 1'b1;
        applyStimulus(4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("midreset_pcsrc", pc_src, 1'b0);
        tick();
        checkOutput("midreset_flags", flags, 4'b0000);
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
Consumer end of the ALU status interface. It captures ALUFlags {N,Z,C,V} from the alu into an architectural flag register under per-group write enables. It evaluates the 4-bit instruction condition field against the stored flags and gates the controller's PC, register-file and memory write strobes. It sits between the controller/decoder and the datapath, downstream of alu.

Parameters:
n, 4, ALU data width; informational only; the flag interface is fixed at 4 bits.
RESET_FLAGS, 4'b0000, value loaded into the flag register {N,Z,C,V} on reset.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
Cond  input  4  instruction condition field (encoding below)
ALUFlags  input  4  {N,Z,C,V} from alu, bit3=N, bit2=Z, bit1=C, bit0=V
FlagW  input  2  flag write request; [1] updates N,Z; [0] updates C,V
PCS  input  1  controller request to write PC
RegW  input  1  controller request to write register file
MemW  input  1  controller request to write memory
NoWrite  input  1  compare-type op; suppresses RegWrite only
PCSrc  output  1  gated PC write
RegWrite  output  1  gated register write
MemWrite  output  1  gated memory write
CondEx  output  1  condition passed (combinational on stored flags)
Flags  output  4  current flag register {N,Z,C,V}

Behaviour:
- Flag register: 4 flops, written on posedge clk only.
  - reset=1: Flags <= RESET_FLAGS, overriding all writes.
  - Otherwise: if FlagW[1]&CondEx then Flags[3:2] <= ALUFlags[3:2]; if FlagW[0]&CondEx then Flags[1:0] <= ALUFlags[1:0]; unwritten bits hold.
- CondEx: combinational from Cond and the stored Flags, never from ALUFlags. An instruction's own flag write does not affect its own condition; it is visible from the next cycle (1-cycle latency).
- Cond decode:
  - 0000 EQ Z; 0001 NE ~Z
  - 0010 CS C; 0011 CC ~C
  - 0100 MI N; 0101 PL ~N
  - 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 reserved, 0
  - Any X/Z bit in Cond yields CondEx=0.
- Write gating:
  - PCSrc = PCS & CondEx
  - RegWrite = RegW & CondEx & ~NoWrite
  - MemWrite = MemW & CondEx
- During reset=1, PCSrc, RegWrite and MemWrite are forced to 0. CondEx and Flags still reflect the decode and register contents.
- Reset values after the reset edge: Flags=RESET_FLAGS. PCSrc, RegWrite and MemWrite are 0 while reset is held. CondEx follows Cond decode on RESET_FLAGS.
- Simultaneous events:
  - FlagW=11 with CondEx=1 updates all four flags on the same edge.
  - FlagW!=0 with CondEx=0 leaves Flags unchanged.
  - reset asserted on the same edge as a flag write: reset wins.
- No internal state other than the flag register; no handshakes; outputs are valid in the same cycle as their inputs.

Test Plan:
- Reset: reset=1 for 1 edge, with ALUFlags=1111 and FlagW=11 -> Flags=0000; PCSrc, RegWrite and MemWrite are 0 while reset=1.
- Flag capture and latency: Cond=1110, FlagW=11, ALUFlags=1001 (5+3, n=4) -> Flags=1001 after the edge. Next cycle Cond=1011 (LT) -> CondEx=0, because N==V. Cond=1010 (GE) -> CondEx=1.
- Partial write: Flags=1001; FlagW=10, ALUFlags=0110 -> Flags=0101. Then FlagW=01, ALUFlags=1010 -> Flags=0110.
- Condition-failed suppression: Flags=0100 (Z); Cond=0001 (NE), FlagW=11, ALUFlags=1111, PCS=RegW=MemW=1 -> CondEx=0; PCSrc, RegWrite and MemWrite are 0; Flags stays 0100.
- Compare op: Flags=0000, Cond=1110, RegW=1, NoWrite=1, FlagW=11, ALUFlags=0110 (0-0 SUB) -> RegWrite=0; Flags=0110 next cycle; then Cond=0000 (EQ) -> CondEx=1.
- Full sweep: for each of the 16 Flags values and 16 Cond values, CondEx matches the decode table. Cond=1111 -> CondEx=0 for all Flags.
